// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and helpers for the halfword-RAM arbiter.
//   arb_state_t     : transfer sequencer states (IDLE, HI, LO)
//   grant_t         : which requester owns the current access
//   HALF_ADDR_W_DEF : default halfword index width (4096 halfwords)
//   merge_half()    : per-byte merge of new data over an old halfword
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam int HALF_ADDR_W_DEF = 12;

    // be2[1] selects the upper byte, be2[0] the lower byte.
    function automatic logic [15:0] merge_half(input logic [15:0] old16,
                                               input logic [15:0] new16,
                                               input logic [1:0]  be2);
        merge_half[15:8] = be2[1] ? new16[15:8] : old16[15:8];
        merge_half[7:0]  = be2[0] ? new16[7:0]  : old16[7:0];
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2
// Two-requester round-robin picker. The grant is combinational; the
// last_grant history register advances only when update is pulsed.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   req_instr     : instruction-fetch port requesting
//   req_data      : data port requesting
//   update        : a grant is being taken this cycle
//   grant         : port chosen this cycle
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_instr,
    input  logic   req_data,
    input  logic   update,
    output grant_t grant
);

    grant_t last_grant;

    // On contention the port that did not win last time goes next.
    always_comb begin
        grant = GNT_INSTR;
        if (req_instr && req_data)
            grant = (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        else if (req_data)
            grant = GNT_DATA;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_grant <= GNT_INSTR;
        else if (update)
            last_grant <= grant;
    end

endmodule

// File: rtl/mem_arbiter_16.sv
// mem_arbiter_16
// Shares a 16-bit-wide test RAM between the instruction-fetch and data
// ports. Every 32-bit access is two halfword cycles, upper half first.
// Byte-enabled writes merge over the RAM's combinational read data.
// Optional macro: MEM_ARB_ASSERT_EN enables simulation protocol checks.
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   instr_address/read                : fetch request (read only)
//   instr_waitrequest/readdata        : fetch completion and data
//   data_address/read/write           : data request, write wins
//   data_byteenable/writedata         : write lane enables and data
//   data_waitrequest/readdata         : data completion and data
//   ram_address                       : halfword index, zero-extended
//   ram_read/ram_write/ram_writedata  : RAM strobes, data in [15:0]
//   ram_readdata                      : RAM read data in [15:0]
//
// state | meaning
// IDLE  | no access in flight; take a grant if anyone requests
// HI    | upper halfword at even index
// LO    | lower halfword at index+1; granted port completes
module mem_arbiter_16
    import mem_arb_pkg::*;
#(
    parameter int HALF_ADDR_W = HALF_ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic        instr_waitrequest,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,
    output logic [31:0] ram_address,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata
);

    arb_state_t               state_q, state_d;
    grant_t                   gnt_q, gnt_pick;
    logic                     wr_q;
    logic [3:0]               be_q;
    logic [31:0]              wdata_q;
    logic [HALF_ADDR_W-2:0]   pair_q;
    logic [15:0]              hi_q;
    logic                     req_instr, req_data, take;
    logic                     wr_en, done;
    logic [HALF_ADDR_W-1:0]   idx;

    assign req_instr = instr_read;
    assign req_data  = data_read | data_write;
    assign take      = (state_q == IDLE) && (req_instr || req_data);

    mem_arb_rr2 u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_instr (req_instr),
        .req_data  (req_data),
        .update    (take),
        .grant     (gnt_pick)
    );

    // The access is latched at grant so a requester that drops mid-transfer
    // cannot corrupt the sequence already under way.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= GNT_INSTR;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            pair_q  <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q   <= gnt_pick;
                wr_q    <= (gnt_pick == GNT_DATA) && data_write;
                be_q    <= data_byteenable;
                wdata_q <= data_writedata;
                pair_q  <= (gnt_pick == GNT_DATA) ? data_address[HALF_ADDR_W:2]
                                                  : instr_address[HALF_ADDR_W:2];
            end
            if (state_q == HI)
                hi_q <= ram_readdata[15:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        idx           = '0;
        ram_read      = 1'b0;
        wr_en         = 1'b0;
        ram_writedata = '0;
        done          = 1'b0;
        case (state_q)
            IDLE: if (take) state_d = HI;
            HI: begin
                state_d  = LO;
                idx      = {pair_q, 1'b0};
                ram_read = 1'b1;
                if (wr_q) begin
                    wr_en         = |be_q[3:2];
                    ram_writedata = {16'h0, merge_half(ram_readdata[15:0],
                                                       wdata_q[31:16], be_q[3:2])};
                end
            end
            LO: begin
                state_d  = IDLE;
                idx      = {pair_q, 1'b1};
                ram_read = 1'b1;
                done     = reset_n;
                if (wr_q) begin
                    wr_en         = |be_q[1:0];
                    ram_writedata = {16'h0, merge_half(ram_readdata[15:0],
                                                       wdata_q[15:0], be_q[1:0])};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset landing mid-access must not let the pending half reach the RAM.
    assign ram_write   = wr_en & reset_n;
    assign ram_address = {{(32-HALF_ADDR_W){1'b0}}, idx};

    assign instr_waitrequest = !(done && gnt_q == GNT_INSTR);
    assign data_waitrequest  = !(done && gnt_q == GNT_DATA);
    assign instr_readdata    = (done && gnt_q == GNT_INSTR) ? {hi_q, ram_readdata[15:0]} : '0;
    assign data_readdata     = (done && gnt_q == GNT_DATA)  ? {hi_q, ram_readdata[15:0]} : '0;

    logic unused_bits;
    assign unused_bits = ^{instr_address[31:HALF_ADDR_W+1], instr_address[1:0],
                           data_address[31:HALF_ADDR_W+1], data_address[1:0],
                           ram_readdata[31:16]};

`ifdef MEM_ARB_ASSERT_EN
    logic [31:0] chk_addr_q;
    logic [1:0]  chk_strb_q;

    always @(posedge clk) begin
        if (reset_n) begin
            if (instr_read && instr_address[1:0] != 2'b00)
                $error("mem_arbiter_16: unaligned instr address %h", instr_address);
            if (req_data && data_address[1:0] != 2'b00)
                $error("mem_arbiter_16: unaligned data address %h", data_address);
            if (data_read && data_write)
                $error("mem_arbiter_16: data_read and data_write both high");
            if (take) begin
                chk_addr_q <= (gnt_pick == GNT_DATA) ? data_address : instr_address;
                chk_strb_q <= (gnt_pick == GNT_DATA) ? {data_read, data_write}
                                                     : {instr_read, 1'b0};
            end else if (state_q == HI) begin
                if (gnt_q == GNT_DATA &&
                    (data_address != chk_addr_q || {data_read, data_write} != chk_strb_q))
                    $error("mem_arbiter_16: data request changed before completion");
                if (gnt_q == GNT_INSTR &&
                    (instr_address != chk_addr_q || {instr_read, 1'b0} != chk_strb_q))
                    $error("mem_arbiter_16: instr request changed before completion");
            end
        end
    end
`endif

endmodule

// File: doc/mem_arbiter_16.md
# mem_arbiter_16

Shares one 16-bit-wide, 4096-entry test RAM between the CPU's instruction-fetch port and data port. Each 32-bit word access is split into two sequential halfword accesses: upper half first (big-endian), then lower. Two-requester round-robin arbitration on each 32-bit access. Byte-enabled writes use read-modify-write, which relies on the RAM's combinational read.

## Interface
Parameters:
- HALF_ADDR_W, 12, halfword index width into the RAM (4096 halfwords = 8 KiB).

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset_n  in  1  reset; **synchronous, active-low**
- instr_address  in  32  byte address; bits [1:0] ignored
- instr_read  in  1  fetch request; hold until waitrequest low
- instr_waitrequest  out  1  high = transfer not complete
- instr_readdata  out  32  valid only in the cycle waitrequest is low
- data_address  in  32  byte address; bits [1:0] ignored
- data_read / data_write  in  1 each  request; write wins if both high
- data_byteenable  in  4  bit3 selects [31:24] … bit0 selects [7:0]
- data_writedata  in  32  write data
- data_waitrequest  out  1  as instr
- data_readdata  out  32  as instr
- ram_address  out  32  halfword index, zero-extended from HALF_ADDR_W
- ram_read / ram_write  out  1 each  RAM strobes
- ram_writedata  out  32  merged halfword in [15:0]; [31:16] = 0
- ram_readdata  in  32  RAM output; [15:0] used

## Operation
- Halfword index: idx = address[HALF_ADDR_W:1] with bit 1 forced 0, so idx is always even. Upper half is at idx, lower half at idx+1; idx+1 never wraps.
- FSM states: IDLE → HI → LO → IDLE.
  - IDLE: if any request is pending, latch the grant and go to HI. Otherwise stay.
  - HI: go to LO.
  - LO: go to IDLE.
- Arbitration:
  - Round-robin using the last_grant register.
  - If both ports request in IDLE, grant the port that is not last_grant.
  - last_grant updates when a grant is taken.
  - last_grant resets to INSTR, so the first contention goes to data.
- HI cycle:
  - ram_address = idx, ram_read = 1.
  - Capture ram_readdata[15:0] into hi_q.
  - Write: ram_write = |be[3:2]; ram_writedata = per-byte merge of writedata[31:16] (be[3:2]) over ram_readdata[15:0].
- LO cycle:
  - ram_address = idx+1, ram_read = 1.
  - Write: ram_write = |be[1:0]; merge writedata[15:0] (be[1:0]).
  - Granted port's readdata = {hi_q, ram_readdata[15:0]}, and its waitrequest = 0.
- Instruction port never writes.
- waitrequest is high in every cycle other than the granted port's LO cycle, including the idle, ungranted and reset cycles.
- A requester must hold its address, strobes, byteenable and writedata stable until it sees waitrequest low. If a request drops mid-transfer, the transfer still runs to completion; the result is discarded.

## Timing
- Latency: waitrequest is low in cycle 2 when counted from the IDLE cycle (cycle 0) in which the grant is taken.
  - 3 cycles per access; at most one access per 3 cycles.
- Reset values:
  - state = IDLE, last_grant = INSTR, hi_q = 0.
  - Both waitrequest = 1.
  - ram_read = ram_write = 0, ram_address = 0, ram_writedata = 0.
  - readdata outputs = 0.
- Reset asserted during HI or LO:
  - Forces IDLE on the next edge.
  - While reset_n is low, ram_write is combinationally gated to 0.
  - An upper half already written in HI is not rolled back (torn write accepted).
- A request arriving in LO is not seen until the following IDLE cycle.
- A write with be = 0000 takes 3 cycles and performs no RAM write.

## Configuration
- MEM_ARB_ASSERT_EN
  - Defined: simulation checks raise $error when:
    - address[1:0] ≠ 0 on a request;
    - a granted request's address or strobes change before waitrequest falls;
    - data_read and data_write are both high.
  - Undefined: no checks; behaviour as above.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, HI, LO};
  - grant enum {GNT_INSTR, GNT_DATA};
  - constant HALF_ADDR_W_DEF = 12;
  - function merge_half(old16, new16, be2).
- Sub-module mem_arb_rr2: two-requester round-robin picker. It owns last_grant and outputs the grant on an update strobe.

## Test plan
- Instruction read:
  - Stimulus: RAM[0x010]=0x1234, RAM[0x011]=0x5678; instr_read with address 0x20.
  - Response: instr_readdata = 0x12345678, instr_waitrequest low for exactly one cycle (cycle 2).
- Full-word write:
  - Stimulus: data write to 0x40, data 0xAABBCCDD, be = 1111.
  - Response: RAM[0x20] = 0xAABB, RAM[0x21] = 0xCCDD; a subsequent read returns 0xAABBCCDD.
- Byte write:
  - Stimulus: RAM as in the first test; data write to 0x20, data 0x0000EE00, be = 0010.
  - Response: RAM[0x011] = 0xEE78, RAM[0x010] = 0x1234; ram_write is 0 in the HI cycle.
- Contention:
  - Stimulus: both ports request in the first cycle after reset.
  - Response: data completes at cycle 2, instr at cycle 5. If both are re-requested, instr is granted next (alternation).
- Reset mid-write:
  - Stimulus: deassert reset_n in the LO cycle of a 0xAABBCCDD write to 0x40.
  - Response: RAM[0x20] = 0xAABB, RAM[0x21] unchanged; both waitrequest = 1; FSM in IDLE.
- Top of memory:
  - Stimulus: data read of 0x1FFC.
  - Response: ram_address = 0xFFE, then 0xFFF; no wrap.
